div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_if.sv | 22 ++
 rtl/div_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/div_if.sv
// Handshake and operand bundle between the issuing pipeline stage and div_unit.
// master drives requests; slave (the divider) returns result/ready/busy.
interface div_if;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, busy
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, busy
    );
endinterface

// File: rtl/div_unit.sv
// 32-bit restoring radix-2 divider, one quotient bit per cycle, result = {remainder, quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one edge with {opdata1, 32'hFFFFFFFF}.
module div_unit (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [31:0] dividend_reg;
    logic [31:0] divisor_reg;
    logic [31:0] rem_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [63:0] result_reg;

    logic        accept;
    logic        div_zero;
    logic        op1_neg, op2_neg;
    logic [31:0] abs1, abs2;
    logic [32:0] shifted;
    logic        q_bit;
    logic [31:0] rem_it, quo_it, q_fix, r_fix;

    assign accept  = (state_reg == IDLE) && bus.start && !bus.annul;

`ifdef DIV_ZERO_FAST_EN
    assign div_zero = (bus.opdata2 == 32'd0);
`else
    assign div_zero = 1'b0;
`endif

    assign op1_neg = bus.signed_div & bus.opdata1[31];
    assign op2_neg = bus.signed_div & bus.opdata2[31];
    assign abs1    = op1_neg ? (32'd0 - bus.opdata1) : bus.opdata1;
    assign abs2    = op2_neg ? (32'd0 - bus.opdata2) : bus.opdata2;

    // The shifted partial remainder needs 33 bits when the divisor is above 2^31;
    // the restored or subtracted value always fits back into 32 bits.
    assign shifted = {rem_reg, dividend_reg[31]};
    assign q_bit   = (shifted >= {1'b0, divisor_reg});
    assign rem_it  = shifted[31:0] - (q_bit ? divisor_reg : 32'd0);
    assign quo_it  = {dividend_reg[30:0], q_bit};
    assign q_fix   = neg_q_reg ? (32'd0 - quo_it) : quo_it;
    assign r_fix   = neg_r_reg ? (32'd0 - rem_it) : rem_it;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start && !bus.annul) begin
                    state_next = div_zero ? DONE : DIV;
                end
            end
            DIV: begin
                if (bus.annul) begin
                    state_next = IDLE;
                end else if (cnt_reg == 5'd31) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Level handshake: hold until the consumer drops start.
                if (bus.annul || !bus.start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= 5'd0;
            dividend_reg <= 32'd0;
            divisor_reg  <= 32'd0;
            rem_reg      <= 32'd0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            result_reg   <= 64'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        dividend_reg <= abs1;
                        divisor_reg  <= abs2;
                        rem_reg      <= 32'd0;
                        cnt_reg      <= 5'd0;
                        neg_q_reg    <= op1_neg ^ op2_neg;
                        neg_r_reg    <= op1_neg;
                        if (div_zero) begin
                            result_reg <= {bus.opdata1, 32'hFFFF_FFFF};
                        end
                    end
                end
                DIV: begin
                    if (!bus.annul) begin
                        dividend_reg <= quo_it;
                        rem_reg      <= rem_it;
                        cnt_reg      <= cnt_reg + 5'd1;
                        if (cnt_reg == 5'd31) begin
                            result_reg <= {r_fix, q_fix};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_reg;
    assign bus.ready  = (state_reg == DONE);
    assign bus.busy   = (state_reg == DIV);
endmodule
